// File: rtl/div_128_64.sv
// Radix-2 restoring unsigned divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, valid/ready request and one-cycle result strobe.
module div_128_64 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_VALID,
    output logic                 o_READY,
    input  logic [2*WIDTH-1:0]   i_DIVIDEND,
    input  logic [WIDTH-1:0]     i_DIVISOR,
    output logic                 o_VALID,
    output logic [WIDTH-1:0]     o_QUOTIENT,
    output logic [WIDTH-1:0]     o_REMAINDER,
    output logic                 o_DIV_ZERO,
    output logic                 o_OVERFLOW
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH:0]     prem_q, prem_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 dz_q, dz_d;
    logic                 ov_q, ov_d;

    logic [2*WIDTH:0]     shifted;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH:0]     step;

    always_comb begin
        state_d   = state_q;
        prem_d    = prem_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        ov_d      = ov_q;

        // Quotient bits enter at bit 0 while dividend bits move up into the remainder half.
        shifted = prem_q << 1;
        diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_q};
        if (shifted[2*WIDTH:WIDTH] >= {1'b0, divisor_q}) begin
            step = {diff, shifted[WIDTH-1:1], 1'b1};
        end else begin
            step = shifted;
        end

        case (state_q)
            IDLE: begin
                if (i_VALID) begin
                    if (i_DIVISOR == '0) begin
                        quo_d   = '1;
                        rem_d   = i_DIVIDEND[WIDTH-1:0];
                        dz_d    = 1'b1;
                        ov_d    = 1'b0;
                        state_d = DONE;
                    end else if (i_DIVIDEND[2*WIDTH-1:WIDTH] >= i_DIVISOR) begin
                        quo_d   = '1;
                        rem_d   = '0;
                        dz_d    = 1'b0;
                        ov_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        prem_d    = {1'b0, i_DIVIDEND};
                        divisor_d = i_DIVISOR;
                        cnt_d     = '0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                prem_d = step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quo_d   = step[WIDTH-1:0];
                    rem_d   = step[2*WIDTH-1:WIDTH];
                    dz_d    = 1'b0;
                    ov_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q   <= IDLE;
            prem_q    <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            prem_q    <= prem_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
            ov_q      <= ov_d;
        end
    end

    assign o_READY     = ready_q;
    assign o_VALID     = valid_q;
    assign o_QUOTIENT  = quo_q;
    assign o_REMAINDER = rem_q;
    assign o_DIV_ZERO  = dz_q;
    assign o_OVERFLOW  = ov_q;

endmodule

// File: tb/tb_div_128_64.sv
// Bench for div_128_64: arithmetic reference model with a per-cycle compare
// process, plus directed literal cases and randomized requests.
module tb_div_128_64;

    localparam int unsigned W = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           vin = 1'b0;
    logic [127:0]   dvd = '0;
    logic [63:0]    dvs = '0;
    logic           o_READY, o_VALID, o_DIV_ZERO, o_OVERFLOW;
    logic [63:0]    o_QUOTIENT, o_REMAINDER;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_128_64 #(.WIDTH(W)) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_VALID     (vin),
        .o_READY     (o_READY),
        .i_DIVIDEND  (dvd),
        .i_DIVISOR   (dvs),
        .o_VALID     (o_VALID),
        .o_QUOTIENT  (o_QUOTIENT),
        .o_REMAINDER (o_REMAINDER),
        .o_DIV_ZERO  (o_DIV_ZERO),
        .o_OVERFLOW  (o_OVERFLOW)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Result defined arithmetically: true quotient, exceptions when it cannot be formed.
    task automatic ref_div(input logic [127:0] a, input logic [63:0] b,
                           output logic [63:0] q, output logic [63:0] r,
                           output logic dz, output logic ov);
        logic [127:0] qq, rr;
        dz = 1'b0; ov = 1'b0;
        if (b == 64'd0) begin
            q = '1; r = a[63:0]; dz = 1'b1;
        end else begin
            qq = a / {64'd0, b};
            rr = a % {64'd0, b};
            if (qq[127:64] != 64'd0) begin
                q = '1; r = '0; ov = 1'b1;
            end else begin
                q = qq[63:0]; r = rr[63:0];
            end
        end
    endtask

    // Model: a request is busy from its accept edge through its result cycle.
    bit           pending = 1'b0;
    bit           busy_before;
    int           cyc = 0;
    int           due = 0;
    logic [63:0]  m_q, m_r, h_q = '0, h_r = '0;
    logic         m_dz, m_ov, h_dz = 1'b0, h_ov = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending = 1'b0;
            h_q = '0; h_r = '0; h_dz = 1'b0; h_ov = 1'b0;
        end else begin
            cyc++;
            busy_before = pending;
            if (pending && cyc == due + 1) pending = 1'b0;
            if (!busy_before && vin) begin
                ref_div(dvd, dvs, m_q, m_r, m_dz, m_ov);
                due = cyc + ((m_dz || m_ov) ? 0 : int'(W));
                pending = 1'b1;
            end
            if (pending && cyc == due) begin
                h_q = m_q; h_r = m_r; h_dz = m_dz; h_ov = m_ov;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready",     o_READY,     !pending);
        chk("valid",     o_VALID,     pending && cyc == due);
        chk("quotient",  o_QUOTIENT,  h_q);
        chk("remainder", o_REMAINDER, h_r);
        chk("div_zero",  o_DIV_ZERO,  h_dz);
        chk("overflow",  o_OVERFLOW,  h_ov);
    end

    task automatic req(input logic [127:0] a, input logic [63:0] b);
        @(negedge clk);
        dvd = a; dvs = b; vin = 1'b1;
        for (int i = 0; i < 200 && !o_READY; i++) @(negedge clk);
        if (!o_READY) chk("ready_timeout", o_READY, 1'b1);
        @(posedge clk);
        #1 vin = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!o_VALID && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        chk("valid_timeout", o_VALID, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [63:0] eq, er, hi, lo, b;
        logic edz, eov;
        int mode;

        #1 rst = 1'b1;
        #1;
        chk("rst_ready", o_READY, 1'b1);
        chk("rst_valid", o_VALID, 1'b0);
        chk("rst_quo",   o_QUOTIENT, 64'd0);
        chk("rst_rem",   o_REMAINDER, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("idle_valid", o_VALID, 1'b0);

        req(128'd100, 64'd7);
        wait_valid(n);
        chk("basic_lat", n, 65);
        chk("basic_q", o_QUOTIENT, 64'd14);
        chk("basic_r", o_REMAINDER, 64'd2);
        chk("basic_flags", {o_DIV_ZERO, o_OVERFLOW}, 2'b00);
        chk("basic_ready", o_READY, 1'b0);

        req(128'hFFFFFFFFFFFFFFFE0000000000000001, 64'hFFFFFFFFFFFFFFFF);
        wait_valid(n);
        chk("rt_q", o_QUOTIENT, 64'hFFFFFFFFFFFFFFFF);
        chk("rt_r", o_REMAINDER, 64'd0);

        req(128'h1_0000_0000_0000_0000, 64'd3);
        dvd = 128'd10; dvs = 64'd3; vin = 1'b1;
        wait_valid(n);
        chk("p64_q", o_QUOTIENT, 64'h5555555555555555);
        chk("p64_r", o_REMAINDER, 64'd1);
        @(posedge clk); #1 chk("b2b_idle", o_READY, 1'b1);
        @(posedge clk); #1 chk("b2b_accept", o_READY, 1'b0);
        vin = 1'b0;
        wait_valid(n);
        chk("b2b_lat", n, 65);
        chk("b2b_q", o_QUOTIENT, 64'd3);
        chk("b2b_r", o_REMAINDER, 64'd1);

        req(128'h1234, 64'd0);
        wait_valid(n);
        chk("dz_lat", n, 1);
        chk("dz_flag", {o_DIV_ZERO, o_OVERFLOW}, 2'b10);
        chk("dz_q", o_QUOTIENT, 64'hFFFFFFFFFFFFFFFF);
        chk("dz_r", o_REMAINDER, 64'h1234);

        req({64'd5, 64'd77}, 64'd5);
        wait_valid(n);
        chk("ov_lat", n, 1);
        chk("ov_flag", {o_DIV_ZERO, o_OVERFLOW}, 2'b01);
        chk("ov_q", o_QUOTIENT, 64'hFFFFFFFFFFFFFFFF);
        chk("ov_r", o_REMAINDER, 64'd0);

        req(128'd1000, 64'd3);
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", o_VALID, 1'b0);
        chk("mid_rst_ready", o_READY, 1'b1);
        chk("mid_rst_q", o_QUOTIENT, 64'd0);
        @(negedge clk) rst = 1'b0;
        repeat (70) @(posedge clk);
        req(128'd1000, 64'd3);
        wait_valid(n);
        chk("after_rst_q", o_QUOTIENT, 64'd333);
        chk("after_rst_r", o_REMAINDER, 64'd1);

        req(128'h0000000000000123_456789ABCDEF0000, 64'h0000_0001_0000_0001);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vin = 1'($urandom);
            dvd = {$urandom, $urandom, $urandom, $urandom};
            dvs = {$urandom, $urandom};
        end
        vin = 1'b0;
        wait_valid(n);
        ref_div(128'h0000000000000123_456789ABCDEF0000, 64'h0000_0001_0000_0001, eq, er, edz, eov);
        chk("toggle_q", o_QUOTIENT, eq);
        chk("toggle_r", o_REMAINDER, er);

        for (int k = 0; k < 30; k++) begin
            mode = $urandom_range(0, 3);
            b  = {$urandom, $urandom};
            lo = {$urandom, $urandom};
            hi = {$urandom, $urandom};
            case (mode)
                0: begin if (b == 0) b = 64'd1; hi = hi % b; end
                1: begin b = 64'($urandom_range(1, 1000)); hi = 64'($urandom) % b; end
                2: b = 64'd0;
                default: begin if (b == 0) b = 64'd1; hi = b; end
            endcase
            repeat ($urandom_range(0, 3)) @(posedge clk);
            req({hi, lo}, b);
            wait_valid(n);
            ref_div({hi, lo}, b, eq, er, edz, eov);
            chk("rand_lat", n, (edz || eov) ? 1 : 65);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
